// File: rtl/dbus_uncached_responder.sv
// Purpose : responder end of the uncached data bus; posts stores into a small
//           write buffer, orders loads behind them, and issues single-beat
//           req/ack/rvalid memory requests.
// Latency : stores complete in 0 cycles while the buffer has room; a load
//           takes 4 cycles with a fully pipelined memory and an empty buffer.
// Backpressure: dbus_stall rises on a full buffer, on any load until its data
//           returns, and on stores while a load is in flight; mem_req is held
//           until mem_ack.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   dbus_read / dbus_write    load / store request from the core
//   dbus_address              word-aligned physical byte address
//   dbus_byteenable/_wrdata   store lanes and data
//   dbus_stall                combinational "not completed this cycle"
//   dbus_rddata               data of the last completed load (registered)
//   mem_req/we/addr/be/wdata  registered memory request, held until mem_ack
//   mem_ack                   request accepted
//   mem_rvalid / mem_rdata    one read-data pulse per accepted read
//
// Build option: define UNCACHED_WBUF_MERGE_EN to let a store to the same word
// as the newest buffered entry merge into it (byte-lane wise) instead of
// allocating a new entry.

module dbus_uncached_responder #(
    parameter int WBUF_DEPTH = 4,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  dbus_read,
    input  logic                  dbus_write,
    input  logic [ADDR_WIDTH-1:0] dbus_address,
    input  logic [3:0]            dbus_byteenable,
    input  logic [31:0]           dbus_wrdata,
    output logic                  dbus_stall,
    output logic [31:0]           dbus_rddata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata
);

    localparam int AW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RD_REQ  = 2'd1;
    localparam logic [1:0] S_RD_WAIT = 2'd2;
    localparam logic [1:0] S_RD_DONE = 2'd3;

    logic [1:0]            r_state;
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [CW-1:0]         r_count;

    logic [ADDR_WIDTH-1:0] r_wb_addr [WBUF_DEPTH];
    logic [3:0]            r_wb_be   [WBUF_DEPTH];
    logic [31:0]           r_wb_data [WBUF_DEPTH];

    logic                  r_mem_req;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [3:0]            r_mem_be;
    logic [31:0]           r_mem_wdata;
    logic [31:0]           r_rddata;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_idle;
    logic                  w_head_presented;
    logic                  w_pop;
    logic                  w_load_head;
    logic                  w_rd_start;
    logic                  w_merge;
    logic                  w_enq;
    logic                  w_stall;
    logic [3:0]            w_head_be;
    logic [31:0]           w_head_data;

    // Full is derived from the registered count only, so a drain ack in the
    // same cycle never frees a slot for a store until the next cycle.
    assign w_full           = (r_count == CW'(WBUF_DEPTH));
    assign w_empty          = (r_count == '0);
    assign w_idle           = (r_state == S_IDLE);
    assign w_head_presented = r_mem_req & r_mem_we;
    assign w_pop            = w_head_presented & mem_ack;
    // A drain request is launched only from a quiet port, which leaves a
    // one-cycle gap after each ack and avoids any ack-to-req path.
    assign w_load_head      = w_idle & ~r_mem_req & ~w_empty;
    // Empty buffer plus no request in flight means every earlier store has
    // been acked, so the load may go out.
    assign w_rd_start       = w_idle & ~r_mem_req & w_empty & dbus_read;

`ifdef UNCACHED_WBUF_MERGE_EN
    logic [AW-1:0] w_tail_idx;
    logic [3:0]    w_merge_be;
    logic [31:0]   w_merge_data;

    assign w_tail_idx = r_tail - AW'(1);

    // The newest entry is off-limits only while it is the head already
    // sitting on mem_*; with one entry in the buffer the newest is the head.
    assign w_merge = w_idle & dbus_write & ~w_empty
                   & (r_wb_addr[w_tail_idx][ADDR_WIDTH-1:2] == dbus_address[ADDR_WIDTH-1:2])
                   & ~((r_count == CW'(1)) & w_head_presented);

    assign w_merge_be = r_wb_be[w_tail_idx] | dbus_byteenable;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_merge_data[8*i +: 8] = dbus_byteenable[i] ? dbus_wrdata[8*i +: 8]
                                                        : r_wb_data[w_tail_idx][8*i +: 8];
        end
    end

    // If the head is launched in the same cycle it absorbs a merge, launch
    // the merged value so the buffer and the bus never disagree.
    assign w_head_be   = (w_merge && (w_tail_idx == r_head)) ? w_merge_be   : r_wb_be[r_head];
    assign w_head_data = (w_merge && (w_tail_idx == r_head)) ? w_merge_data : r_wb_data[r_head];
`else
    assign w_merge     = 1'b0;
    assign w_head_be   = r_wb_be[r_head];
    assign w_head_data = r_wb_data[r_head];
`endif

    assign w_enq = w_idle & dbus_write & ~w_full & ~w_merge;

    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (dbus_read)
                    w_stall = 1'b1;
                else if (dbus_write)
                    w_stall = w_full & ~w_merge;
            end
            S_RD_REQ,
            S_RD_WAIT: w_stall = dbus_read | dbus_write;
            // The held load completes here; a store would have to wait.
            S_RD_DONE: w_stall = dbus_write;
            default:   w_stall = 1'b0;
        endcase
    end

    // Buffer storage carries no reset: validity lives in head/tail/count.
    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_wb_addr[r_tail] <= dbus_address;
            r_wb_be[r_tail]   <= dbus_byteenable;
            r_wb_data[r_tail] <= dbus_wrdata;
        end
`ifdef UNCACHED_WBUF_MERGE_EN
        else if (w_merge) begin
            r_wb_be[w_tail_idx]   <= w_merge_be;
            r_wb_data[w_tail_idx] <= w_merge_data;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'h0;
            r_mem_wdata <= 32'h0;
            r_rddata    <= 32'h0;
        end else begin
            if (w_pop)
                r_head <= r_head + AW'(1);
            if (w_enq)
                r_tail <= r_tail + AW'(1);

            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_mem_req <= 1'b0;
                    end else if (w_load_head) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= r_wb_addr[r_head];
                        r_mem_be    <= w_head_be;
                        r_mem_wdata <= w_head_data;
                    end else if (w_rd_start) begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= dbus_address;
                        r_mem_be   <= 4'hF;
                        r_state    <= S_RD_REQ;
                    end
                end
                S_RD_REQ: begin
                    if (mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid) begin
                        r_rddata <= mem_rdata;
                        r_state  <= S_RD_DONE;
                    end
                end
                S_RD_DONE: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign dbus_stall  = w_stall;
    assign dbus_rddata = r_rddata;
    assign mem_req     = r_mem_req;
    assign mem_we      = r_mem_we;
    assign mem_addr    = r_mem_addr;
    assign mem_be      = r_mem_be;
    assign mem_wdata   = r_mem_wdata;

endmodule
